lsu_mem_seq: RTL

LSU_MEM_SEQ -- requirements
Module: lsu_mem_seq

---
 rtl/lsu_mem_seq_if.sv | 33 +++
 rtl/lsu_mem_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/lsu_mem_seq_if.sv
// Bundle of the LSU signals: the core-side instruction fields and the data-memory bus.
// slave is the LSU side; master is the core/memory side that drives the LSU.
interface lsu_mem_seq_if #(
   parameter int ADDR_W = 32
);
   logic [6:0]        i_opcode;
   logic [2:0]        i_funct3;
   logic [ADDR_W-1:0] i_addr;
   logic [31:0]       i_wdata;
   logic              o_mem_req;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdata;
   logic [3:0]        o_mem_be;
   logic              i_mem_ack;
   logic [31:0]       i_mem_rdata;
   logic [31:0]       o_load_data;
   logic              o_stall;
   logic              o_regWrite;
   logic              o_misalign;

   modport slave (
      input  i_opcode, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
             o_load_data, o_stall, o_regWrite, o_misalign
   );

   modport master (
      output i_opcode, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
             o_load_data, o_stall, o_regWrite, o_misalign
   );
endinterface

// File: rtl/lsu_mem_seq.sv
// Multi-cycle load/store sequencer: IDLE -> ACCESS (wait for ack) -> DONE, with lane steering.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and flag o_misalign in DONE.
module lsu_mem_seq #(
   parameter int ADDR_W = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   lsu_mem_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [31:0]       load_q;
   logic              mem_op, is_store;

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         3'b000, 3'b100: byte_en = 4'b0001 << lo;
         3'b001, 3'b101: byte_en = lo[1] ? 4'b1100 : 4'b0011;
         default:        byte_en = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         3'b000, 3'b100: store_lanes = {4{wd[7:0]}};
         3'b001, 3'b101: store_lanes = {2{wd[15:0]}};
         default:        store_lanes = wd;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rd);
      logic [31:0] sh;
      logic [15:0] h;
      sh = rd >> {lo, 3'b000};
      h  = lo[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
         3'b100:  load_extend = {24'd0, sh[7:0]};
         3'b001:  load_extend = {{16{h[15]}}, h};
         3'b101:  load_extend = {16'd0, h};
         default: load_extend = rd;
      endcase
   endfunction

   assign is_store = (bus.i_opcode[6:2] == 5'b01000);
   assign mem_op   = (bus.i_opcode[6:2] == 5'b00000) || is_store;

`ifdef MISALIGN_TRAP_EN
   logic mis_now, mis_q;
   always_comb begin
      case (bus.i_funct3)
         3'b000, 3'b100: mis_now = 1'b0;
         3'b001, 3'b101: mis_now = bus.i_addr[0];
         default:        mis_now = (bus.i_addr[1:0] != 2'b00);
      endcase
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mem_op) begin
`ifdef MISALIGN_TRAP_EN
               state_nxt = mis_now ? DONE : ACCESS;
`else
               state_nxt = ACCESS;
`endif
            end
         end
         ACCESS:  if (bus.i_mem_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Request fields are frozen at IDLE so the bus stays stable however long the ack takes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr_q   <= '0;
         funct3_q <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         load_q   <= '0;
      end else begin
         if (state == IDLE && mem_op) begin
            addr_q   <= bus.i_addr;
            funct3_q <= bus.i_funct3;
            wdata_q  <= bus.i_wdata;
            we_q     <= is_store;
         end
         if (state == ACCESS && bus.i_mem_ack && !we_q)
            load_q <= load_extend(funct3_q, addr_q[1:0], bus.i_mem_rdata);
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                     mis_q <= 1'b0;
      else if (state == IDLE && mem_op) mis_q <= mis_now;
   end
   assign bus.o_misalign = (state == DONE) && mis_q;
   assign bus.o_regWrite = (state == DONE) && !we_q && !mis_q;
`else
   assign bus.o_misalign = 1'b0;
   assign bus.o_regWrite = (state == DONE) && !we_q;
`endif

   assign bus.o_mem_req   = (state == ACCESS);
   assign bus.o_mem_we    = we_q;
   assign bus.o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.o_mem_be    = byte_en(funct3_q, addr_q[1:0]);
   assign bus.o_mem_wdata = store_lanes(funct3_q, wdata_q);
   assign bus.o_load_data = load_q;
   assign bus.o_stall     = mem_op && (state != DONE);
endmodule
